fixed_to_float: RTL and testbench



---
 rtl/fixed_to_float.sv | 141 ++++++++++++++
 tb/tb_fixed_to_float.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fixed_to_float.sv
// Sequential 32-bit two's-complement fixed-point to IEEE-754 single converter.
// Leading-one search normalizes one bit per cycle; valid/ready on both sides.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   in_valid     fixed/fixpointpos valid        in_ready   block accepts input
//   fixed        two's-complement input word    fixpointpos fractional bits
//   out_valid    result valid                   out_ready  consumer accepts
//   result       IEEE-754 single result         busy       not IDLE
//
// Optional: define FIXED_TO_FLOAT_ROUND_NEAREST_EN for round-to-nearest-even
// packing; the default build truncates the low byte of the magnitude.
module fixed_to_float #(
    parameter int WIDTH  = 32,
    parameter int FRAC_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  fixed,
    input  logic [FRAC_W-1:0] fixpointpos,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       result,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        PACK,
        HOLD
    } state_t;

    state_t            state_q;
    logic              sign_q;
    logic [31:0]       mag_q;
    logic [FRAC_W-1:0] fp_q;
    logic [4:0]        s_q;
    logic [31:0]       result_q;
    logic              out_valid_q;
    logic              in_ready_q;
    logic              busy_q;

    logic [31:0] mag_in_d;
    logic [7:0]  exp_d;
    logic [22:0] mant_d;
    logic [31:0] pack_d;

`ifdef FIXED_TO_FLOAT_ROUND_NEAREST_EN
    logic [7:0]  guard_d;
    logic        rnd_d;
    logic [23:0] mant_r_d;
`endif

    // Magnitude of the incoming word; 0x80000000 maps onto itself.
    always_comb begin
        mag_in_d = fixed[31] ? (~fixed + 32'd1) : fixed;
    end

    always_comb begin
        // Range is 96..158, so the low 8 bits hold the full exponent.
        exp_d  = 8'(9'd158 - 9'(s_q) - 9'(fp_q));
        mant_d = mag_q[30:8];
`ifdef FIXED_TO_FLOAT_ROUND_NEAREST_EN
        guard_d  = mag_q[7:0];
        rnd_d    = (guard_d > 8'h80) ||
                   ((guard_d == 8'h80) && mant_d[0]);
        mant_r_d = {1'b0, mant_d} + {23'd0, rnd_d};
        if (mant_r_d[23]) begin
            mant_d = 23'd0;
            exp_d  = exp_d + 8'd1;
        end else begin
            mant_d = mant_r_d[22:0];
        end
`endif
        if (mag_q == 32'd0) begin
            pack_d = 32'h0000_0000;
        end else begin
            pack_d = {sign_q, exp_d, mant_d};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            mag_q       <= 32'd0;
            fp_q        <= '0;
            s_q         <= 5'd0;
            result_q    <= 32'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q     <= fixed[31];
                        mag_q      <= mag_in_d;
                        fp_q       <= fixpointpos;
                        s_q        <= 5'd0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= NORM;
                    end
                end
                NORM: begin
                    if (mag_q[31] || (mag_q == 32'd0)) begin
                        state_q <= PACK;
                    end else begin
                        mag_q <= {mag_q[30:0], 1'b0};
                        s_q   <= s_q + 5'd1;
                    end
                end
                PACK: begin
                    result_q    <= pack_d;
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fixed_to_float.sv
// Directed self-checking bench for fixed_to_float.
// Expected floats and latencies are hand-computed constants.
module tb_fixed_to_float;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] fixed;
    logic [4:0]  fixpointpos;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int checks;
    int errors;

    fixed_to_float dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .fixed       (fixed),
        .fixpointpos (fixpointpos),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one word, return after the accept edge (+1).
    task automatic accept(input logic [31:0] f, input logic [4:0] fp);
        fixed       = f;
        fixpointpos = fp;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges from accept until out_valid, bounded.
    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 100);
    endtask

    task automatic convert(input string name, input logic [31:0] f,
                           input logic [4:0] fp, input logic [31:0] exp_r,
                           input int exp_lat);
        int n;
        out_ready = 1'b1;
        accept(f, fp);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s busy/in_ready after accept: %b/%b want 1/0",
                     name, busy, in_ready);
        end
        wait_out(n);
        checks++;
        if (n !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, n, exp_lat);
        end
        checks++;
        if (result !== exp_r) begin
            errors++;
            $display("FAIL %s result: got %h want %h", name, result, exp_r);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s return to idle: ov=%b ir=%b busy=%b want 0/1/0",
                     name, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            busy !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: ov=%b ir=%b busy=%b res=%h want 0/1/0/0",
                     out_valid, in_ready, busy, result);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_norm;
        int seen;
        out_ready = 1'b1;
        accept(32'h0000_0001, 5'd0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            busy !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_norm: ov=%b ir=%b busy=%b res=%h want 0/1/0/0",
                     out_valid, in_ready, busy, result);
        end
        #8;
        rst = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_discard: active cycles %0d want 0", seen);
        end
    endtask

    task automatic test_basic;
        convert("one",      32'h0000_0001, 5'd0,  32'h3F80_0000, 33);
        convert("one_half", 32'h0001_8000, 5'd16, 32'h3FC0_0000, 17);
        convert("minus2",   32'hFFFF_FFFE, 5'd0,  32'hC000_0000, 32);
        convert("minint",   32'h8000_0000, 5'd0,  32'hCF00_0000, 2);
        convert("zero",     32'h0000_0000, 5'd7,  32'h0000_0000, 2);
    endtask

    task automatic test_rounding;
`ifdef FIXED_TO_FLOAT_ROUND_NEAREST_EN
        convert("tie_even", 32'h0100_0003, 5'd0, 32'h4B80_0002, 9);
        convert("carry",    32'h7FFF_FFFF, 5'd0, 32'h4F00_0000, 3);
`else
        convert("tie_trunc", 32'h0100_0003, 5'd0, 32'h4B80_0001, 9);
        convert("max_trunc", 32'h7FFF_FFFF, 5'd0, 32'h4EFF_FFFF, 3);
`endif
    endtask

    task automatic test_backpressure;
        int n;
        int bad;
        out_ready = 1'b0;
        accept(32'h0001_8000, 5'd16);
        wait_out(n);
        checks++;
        if (n !== 17 || result !== 32'h3FC0_0000) begin
            errors++;
            $display("FAIL bp_first: lat %0d res %h want 17 3fc00000", n, result);
        end
        fixed       = 32'h0000_0001;
        fixpointpos = 5'd0;
        in_valid    = 1'b1;
        bad = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (result !== 32'h3FC0_0000 || out_valid !== 1'b1 ||
                in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bp_hold: %0d bad cycles want 0", bad);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: ov=%b ir=%b want 0/1", out_valid, in_ready);
        end
        convert("after_bp", 32'hFFFF_FFFE, 5'd0, 32'hC000_0000, 32);
    endtask

    task automatic test_back_to_back;
        convert("b2b_a", 32'h8000_0000, 5'd0, 32'hCF00_0000, 2);
        convert("b2b_b", 32'h0000_0000, 5'd0, 32'h0000_0000, 2);
        convert("b2b_c", 32'h0000_0001, 5'd0, 32'h3F80_0000, 33);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        fixed       = 32'h0;
        fixpointpos = 5'd0;
        test_reset;
        test_reset_mid_norm;
        test_basic;
        test_rounding;
        test_backpressure;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
